// File: rtl/cdb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : cdb_reservation_station
// Purpose  : Unified reservation station. Holds dispatched ops, wakes source
//            operands from the CDB and issues one ready op per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_reservation_station #(
    parameter int XLEN_P = 32,
    parameter int PREG_W = 6,
    parameter int DEPTH  = 8,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              disp_valid_i,
    output logic              disp_ready_o,
    input  logic [CTRL_W-1:0] disp_ctrl_i,
    input  logic [PREG_W-1:0] disp_dest_tag_i,
    input  logic [PREG_W-1:0] disp_src1_tag_i,
    input  logic              disp_src1_rdy_i,
    input  logic [XLEN_P-1:0] disp_src1_data_i,
    input  logic [PREG_W-1:0] disp_src2_tag_i,
    input  logic              disp_src2_rdy_i,
    input  logic [XLEN_P-1:0] disp_src2_data_i,
    input  logic              cdb_valid_i,
    input  logic [PREG_W-1:0] cdb_tag_i,
    input  logic [XLEN_P-1:0] cdb_data_i,
    output logic              iss_valid_o,
    input  logic              iss_ready_i,
    output logic [CTRL_W-1:0] iss_ctrl_o,
    output logic [PREG_W-1:0] iss_dest_tag_o,
    output logic [XLEN_P-1:0] iss_src1_data_o,
    output logic [XLEN_P-1:0] iss_src2_data_o,
    output logic [CNT_W-1:0]  occupancy_o
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic              r_valid    [DEPTH];
    logic [CTRL_W-1:0] r_ctrl     [DEPTH];
    logic [PREG_W-1:0] r_dest     [DEPTH];
    logic [PREG_W-1:0] r_s1_tag   [DEPTH];
    logic              r_s1_rdy   [DEPTH];
    logic [XLEN_P-1:0] r_s1_data  [DEPTH];
    logic [PREG_W-1:0] r_s2_tag   [DEPTH];
    logic              r_s2_rdy   [DEPTH];
    logic [XLEN_P-1:0] r_s2_data  [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_has_free;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_any_elig;
    logic               w_alloc;
    logic               w_issue;
    logic               w_byp1;
    logic               w_byp2;

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        w_free_idx = '0;
        w_has_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = c_IDX_W'(i);
                w_has_free = 1'b1;
            end
        end
    end

    // Eligibility uses registered readiness only, so no CDB-to-issue path.
    always_comb begin
        w_sel_idx  = '0;
        w_any_elig = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && r_s1_rdy[i] && r_s2_rdy[i]) begin
                w_sel_idx  = c_IDX_W'(i);
                w_any_elig = 1'b1;
            end
        end
    end

    assign disp_ready_o = w_has_free;
    assign w_alloc      = disp_valid_i && w_has_free;
    assign w_issue      = w_any_elig && iss_ready_i;
    assign w_byp1       = !disp_src1_rdy_i && cdb_valid_i && (cdb_tag_i == disp_src1_tag_i);
    assign w_byp2       = !disp_src2_rdy_i && cdb_valid_i && (cdb_tag_i == disp_src2_tag_i);

    assign iss_valid_o     = w_any_elig;
    assign iss_ctrl_o      = w_any_elig ? r_ctrl[w_sel_idx]    : '0;
    assign iss_dest_tag_o  = w_any_elig ? r_dest[w_sel_idx]    : '0;
    assign iss_src1_data_o = w_any_elig ? r_s1_data[w_sel_idx] : '0;
    assign iss_src2_data_o = w_any_elig ? r_s2_data[w_sel_idx] : '0;
    assign occupancy_o     = r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_ctrl[i]    <= '0;
                r_dest[i]    <= '0;
                r_s1_tag[i]  <= '0;
                r_s1_rdy[i]  <= 1'b0;
                r_s1_data[i] <= '0;
                r_s2_tag[i]  <= '0;
                r_s2_rdy[i]  <= 1'b0;
                r_s2_data[i] <= '0;
            end
            r_count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc && (w_free_idx == c_IDX_W'(i))) begin
                    r_valid[i]   <= 1'b1;
                    r_ctrl[i]    <= disp_ctrl_i;
                    r_dest[i]    <= disp_dest_tag_i;
                    r_s1_tag[i]  <= disp_src1_tag_i;
                    r_s1_rdy[i]  <= disp_src1_rdy_i || w_byp1;
                    r_s1_data[i] <= w_byp1 ? cdb_data_i : disp_src1_data_i;
                    r_s2_tag[i]  <= disp_src2_tag_i;
                    r_s2_rdy[i]  <= disp_src2_rdy_i || w_byp2;
                    r_s2_data[i] <= w_byp2 ? cdb_data_i : disp_src2_data_i;
                end else if (r_valid[i]) begin
                    if (w_issue && (w_sel_idx == c_IDX_W'(i))) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (cdb_valid_i && !r_s1_rdy[i] && (r_s1_tag[i] == cdb_tag_i)) begin
                        r_s1_rdy[i]  <= 1'b1;
                        r_s1_data[i] <= cdb_data_i;
                    end
                    if (cdb_valid_i && !r_s2_rdy[i] && (r_s2_tag[i] == cdb_tag_i)) begin
                        r_s2_rdy[i]  <= 1'b1;
                        r_s2_data[i] <= cdb_data_i;
                    end
                end
            end
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_issue);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_reservation_station
// Purpose  : Scoreboard bench for cdb_reservation_station.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_reservation_station;

    localparam int c_XLEN  = 32;
    localparam int c_PREG  = 6;
    localparam int c_DEPTH = 8;
    localparam int c_CTRL  = 16;
    localparam int c_CNT   = $clog2(c_DEPTH) + 1;

    typedef struct packed {
        logic [c_CTRL-1:0] ctrl;
        logic [c_PREG-1:0] dest;
        logic [c_XLEN-1:0] s1;
        logic [c_XLEN-1:0] s2;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              disp_valid = 1'b0;
    logic              disp_ready;
    logic [c_CTRL-1:0] disp_ctrl = '0;
    logic [c_PREG-1:0] disp_dest = '0;
    logic [c_PREG-1:0] s1_tag = '0;
    logic              s1_rdy = 1'b0;
    logic [c_XLEN-1:0] s1_data = '0;
    logic [c_PREG-1:0] s2_tag = '0;
    logic              s2_rdy = 1'b0;
    logic [c_XLEN-1:0] s2_data = '0;
    logic              cdb_valid = 1'b0;
    logic [c_PREG-1:0] cdb_tag = '0;
    logic [c_XLEN-1:0] cdb_data = '0;
    logic              iss_valid;
    logic              iss_ready = 1'b0;
    logic [c_CTRL-1:0] iss_ctrl;
    logic [c_PREG-1:0] iss_dest;
    logic [c_XLEN-1:0] iss_s1;
    logic [c_XLEN-1:0] iss_s2;
    logic [c_CNT-1:0]  occupancy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    cdb_reservation_station #(
        .XLEN_P(c_XLEN), .PREG_W(c_PREG), .DEPTH(c_DEPTH), .CTRL_W(c_CTRL), .CNT_W(c_CNT)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_ctrl_i(disp_ctrl),
        .disp_dest_tag_i(disp_dest),
        .disp_src1_tag_i(s1_tag), .disp_src1_rdy_i(s1_rdy), .disp_src1_data_i(s1_data),
        .disp_src2_tag_i(s2_tag), .disp_src2_rdy_i(s2_rdy), .disp_src2_data_i(s2_data),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_ctrl_o(iss_ctrl),
        .iss_dest_tag_o(iss_dest), .iss_src1_data_o(iss_s1), .iss_src2_data_o(iss_s2),
        .occupancy_o(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [15:0] ctrl, input logic [5:0] dest,
                            input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                            input logic [5:0] t2, input logic r2, input logic [31:0] d2);
        disp_valid = 1'b1;
        disp_ctrl  = ctrl;
        disp_dest  = dest;
        s1_tag = t1; s1_rdy = r1; s1_data = d1;
        s2_tag = t2; s2_rdy = r2; s2_data = d2;
        tick();
        disp_valid = 1'b0;
    endtask

    // Every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && !flush && iss_valid && iss_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", 32'(iss_ctrl), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("iss_ctrl", 32'(iss_ctrl), 32'(e.ctrl));
                check("iss_dest", 32'(iss_dest), 32'(e.dest));
                check("iss_src1", iss_s1, e.s1);
                check("iss_src2", iss_s2, e.s2);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_occ", 32'(occupancy), 0);
        check("rst_iss_valid", 32'(iss_valid), 0);
        check("rst_disp_ready", 32'(disp_ready), 1);
        check("rst_iss_ctrl", 32'(iss_ctrl), 0);
        check("rst_iss_s1", iss_s1, 0);

        // Both sources ready at dispatch
        iss_ready = 1'b1;
        sb.push_back('{ctrl: 16'h0011, dest: 6'd1, s1: 32'h5, s2: 32'h7});
        dispatch(16'h0011, 6'd1, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 32'h7);
        check("t1_valid", 32'(iss_valid), 1);
        check("t1_occ1", 32'(occupancy), 1);
        tick();
        check("t1_occ0", 32'(occupancy), 0);
        check("t1_valid_after", 32'(iss_valid), 0);

        // Wakeup through CDB two cycles after dispatch
        sb.push_back('{ctrl: 16'h0022, dest: 6'd2, s1: 32'h1, s2: 32'hDEAD});
        dispatch(16'h0022, 6'd2, 6'd0, 1'b1, 32'h1, 6'd12, 1'b0, 32'h0);
        check("t2_wait0", 32'(iss_valid), 0);
        tick();
        check("t2_wait1", 32'(iss_valid), 0);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hDEAD;
        #1;
        check("t2_bcast_cycle", 32'(iss_valid), 0);
        tick();
        cdb_valid = 1'b0;
        check("t2_woken", 32'(iss_valid), 1);
        tick();
        check("t2_occ", 32'(occupancy), 0);

        // Dispatch-cycle bypass
        sb.push_back('{ctrl: 16'h0033, dest: 6'd3, s1: 32'h42, s2: 32'h9});
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h42;
        dispatch(16'h0033, 6'd3, 6'd9, 1'b0, 32'h0, 6'd1, 1'b1, 32'h9);
        cdb_valid = 1'b0;
        check("t3_bypass_valid", 32'(iss_valid), 1);
        tick();
        check("t3_occ", 32'(occupancy), 0);

        // Fill to full, drop a ninth dispatch, then drain in index order
        iss_ready = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin
            sb.push_back('{ctrl: 16'(16'h40 + i), dest: 6'(i), s1: 32'(i * 3), s2: 32'(i + 100)});
            dispatch(16'(16'h40 + i), 6'(i), 6'd0, 1'b1, 32'(i * 3), 6'd0, 1'b1, 32'(i + 100));
        end
        check("t4_occ_full", 32'(occupancy), 8);
        check("t4_not_ready", 32'(disp_ready), 0);
        check("t4_stall_sel", 32'(iss_ctrl), 32'h40);
        dispatch(16'h0099, 6'd9, 6'd0, 1'b1, 32'h99, 6'd0, 1'b1, 32'h99);
        check("t4_drop_occ", 32'(occupancy), 8);
        iss_ready = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) tick();
        check("t4_drained", 32'(occupancy), 0);
        check("t4_idle", 32'(iss_valid), 0);

        // Shared-tag wakeup: entries 0,1,3 wait on tag 3, entry 2 on tag 4
        sb.push_back('{ctrl: 16'h0050, dest: 6'd10, s1: 32'h33, s2: 32'h1});
        sb.push_back('{ctrl: 16'h0051, dest: 6'd11, s1: 32'h2, s2: 32'h33});
        sb.push_back('{ctrl: 16'h0053, dest: 6'd13, s1: 32'h33, s2: 32'h33});
        dispatch(16'h0050, 6'd10, 6'd3, 1'b0, 32'h0, 6'd0, 1'b1, 32'h1);
        dispatch(16'h0051, 6'd11, 6'd0, 1'b1, 32'h2, 6'd3, 1'b0, 32'h0);
        dispatch(16'h0052, 6'd12, 6'd4, 1'b0, 32'h0, 6'd0, 1'b1, 32'h5);
        dispatch(16'h0053, 6'd13, 6'd3, 1'b0, 32'h0, 6'd3, 1'b0, 32'h0);
        check("t5_pending", 32'(iss_valid), 0);
        check("t5_occ4", 32'(occupancy), 4);
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h33;
        tick();
        cdb_valid = 1'b0;
        tick(); tick(); tick();
        check("t5_occ1", 32'(occupancy), 1);
        check("t5_tag4_pending", 32'(iss_valid), 0);
        sb.push_back('{ctrl: 16'h0052, dest: 6'd12, s1: 32'h44, s2: 32'h5});
        cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h44;
        tick();
        cdb_valid = 1'b0;
        tick();
        check("t5_occ0", 32'(occupancy), 0);

        // Flush with concurrent dispatch and broadcast
        for (int i = 0; i < 5; i++) begin
            dispatch(16'(16'h60 + i), 6'(20 + i), 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'h1);
        end
        check("t6_occ5", 32'(occupancy), 5);
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'h77;
        dispatch(16'h006F, 6'd30, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
        flush = 1'b0;
        cdb_valid = 1'b0;
        check("t6_occ0", 32'(occupancy), 0);
        check("t6_iss_valid", 32'(iss_valid), 0);
        check("t6_disp_ready", 32'(disp_ready), 1);
        cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'h88;
        tick();
        cdb_valid = 1'b0;
        check("t6_no_issue", 32'(iss_valid), 0);
        tick();
        check("t6_occ_final", 32'(occupancy), 0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
